// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with an internal synchronous data RAM.
// Latency: non-loads and misaligned ops 1 cycle after accept; aligned loads 2 cycles.
// Backpressure: single-entry output; InReady follows OutReady while holding a result.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   InValid/InReady       EX-side handshake; Ins, Result (address/ALU value), Rdata2 (store data)
//   OutValid/OutReady     WB-side handshake; OutIns, Wdata (write-back value), AddrErr
module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutIns,
  output logic [31:0] Wdata,
  output logic        AddrErr
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------
  // Decode of the instruction presented by EX
  // ---------------------------------------------------------------
  logic [5:0]        opcode;
  logic              is_load;
  logic              is_store;
  logic              is_half;
  logic              is_word;
  logic              misalign;
  logic              aligned_load;
  logic              accept;
  logic              issue_rd;
  logic              do_wr;
  logic [ADDR_W-1:0] word_idx;

  assign opcode   = Ins[31:26];
  assign is_load  = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                    (opcode == OP_LBU) || (opcode == OP_LHU);
  assign is_store = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
  assign is_half  = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
  assign is_word  = (opcode == OP_LW) || (opcode == OP_SW);
  assign misalign = (is_half && Result[0]) || (is_word && (Result[1:0] != 2'b00));

  assign aligned_load = is_load && !misalign;
  assign accept       = InValid && InReady;
  assign issue_rd     = accept && aligned_load;
  // A store coinciding with reset is dropped, so the write is gated by RST too.
  assign do_wr        = accept && is_store && !misalign && !RST;
  assign word_idx     = Result[ADDR_W+1:2];

  // Address bits above the RAM size are ignored (addresses wrap).
  logic unused_result;
  assign unused_result = ^Result[31:ADDR_W+2];

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // aligned_load is used (not issue_rd) so InReady does not loop back on itself.
  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    OutValid  = 1'b0;
    case (state)
      EMPTY: begin
        InReady = 1'b1;
        if (InValid) begin
          state_nxt = aligned_load ? LOAD : FULL;
        end
      end
      LOAD: begin
        state_nxt = FULL;
      end
      FULL: begin
        OutValid = 1'b1;
        InReady  = OutReady;
        if (OutReady) begin
          if (InValid) begin
            state_nxt = aligned_load ? LOAD : FULL;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Store lane steering (big-endian: offset 0 is the MSB lane)
  // ---------------------------------------------------------------
  logic [3:0]  wr_be;
  logic [31:0] wr_word;

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = Rdata2;
    case (opcode)
      OP_SB: begin
        wr_word = {4{Rdata2[7:0]}};
        wr_be   = 4'b1000 >> Result[1:0];
      end
      OP_SH: begin
        wr_word = {2{Rdata2[15:0]}};
        wr_be   = Result[1] ? 4'b0011 : 4'b1100;
      end
      OP_SW: begin
        wr_be   = 4'b1111;
      end
      default: begin
        wr_be   = 4'b0000;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Data RAM: byte-enabled write and registered read, both on the accept edge.
  // Only one access is accepted per edge, so read and write never collide.
  // ---------------------------------------------------------------
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic [31:0] rd_data;

  always_ff @(posedge CLK) begin
    if (do_wr) begin
      if (wr_be[3]) ram[word_idx][31:24] <= wr_word[31:24];
      if (wr_be[2]) ram[word_idx][23:16] <= wr_word[23:16];
      if (wr_be[1]) ram[word_idx][15:8]  <= wr_word[15:8];
      if (wr_be[0]) ram[word_idx][7:0]   <= wr_word[7:0];
    end
    if (issue_rd) begin
      rd_data <= ram[word_idx];
    end
  end

  // ---------------------------------------------------------------
  // Load formatting, applied during the LOAD cycle to the RAM output
  // ---------------------------------------------------------------
  logic [5:0]  ld_op;
  logic [1:0]  ld_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  always_comb begin
    ld_byte = rd_data[31:24];
    case (ld_off)
      2'd0:    ld_byte = rd_data[31:24];
      2'd1:    ld_byte = rd_data[23:16];
      2'd2:    ld_byte = rd_data[15:8];
      default: ld_byte = rd_data[7:0];
    endcase
    ld_half = ld_off[1] ? rd_data[15:0] : rd_data[31:16];
    case (ld_op)
      OP_LB:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_fmt = {24'd0, ld_byte};
      OP_LH:   ld_fmt = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = rd_data;
    endcase
  end

  // ---------------------------------------------------------------
  // Output register. Without an accept or a LOAD cycle nothing changes,
  // which keeps the outputs bit-stable while WB stalls.
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      OutIns  <= 32'd0;
      Wdata   <= 32'd0;
      AddrErr <= 1'b0;
      ld_op   <= 6'd0;
      ld_off  <= 2'd0;
    end else if (accept) begin
      OutIns  <= Ins;
      AddrErr <= misalign;
      ld_op   <= opcode;
      ld_off  <= Result[1:0];
      // Aligned loads get their value in the LOAD cycle; OutValid is low until then.
      if (misalign || is_load) begin
        Wdata <= 32'd0;
      end else begin
        Wdata <= Result;
      end
    end else if (state == LOAD) begin
      Wdata <= ld_fmt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with directed and randomized traffic.
// Latency: expectations queued at accept, consumed when WB takes the output.
// Backpressure: OutReady forced or randomized; outputs compared every valid cycle.
module tb_mem_stage;

  localparam int AW = 10;
  localparam int NB = 4 << AW;

  logic        CLK = 1'b0;
  logic        RST;
  logic        InValid;
  logic        InReady;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutIns;
  logic [31:0] Wdata;
  logic        AddrErr;

  always #5 CLK = ~CLK;

  mem_stage #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .InValid(InValid), .InReady(InReady),
    .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutIns(OutIns), .Wdata(Wdata), .AddrErr(AddrErr)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] wd;
    logic        err;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mref [0:NB-1];
  bit         rand_ready = 1'b0;
  logic       force_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed big-endian memory model.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] res,
                                 input logic [31:0] rd2);
    exp_t e;
    logic [5:0] op;
    int a;
    logic mis;
    op = ins[31:26];
    a = int'(res[AW+1:0]);
    mis = ((op == 6'h21 || op == 6'h25 || op == 6'h29) && res[0]) ||
          ((op == 6'h23 || op == 6'h2B) && res[1:0] != 2'b00);
    e.ins = ins;
    e.err = mis;
    e.wd  = res;
    if (mis) begin
      e.wd = 32'd0;
    end else begin
      case (op)
        6'h20: e.wd = {{24{mref[a][7]}}, mref[a]};
        6'h24: e.wd = {24'd0, mref[a]};
        6'h21: e.wd = {{16{mref[a][7]}}, mref[a], mref[a+1]};
        6'h25: e.wd = {16'd0, mref[a], mref[a+1]};
        6'h23: e.wd = {mref[a], mref[a+1], mref[a+2], mref[a+3]};
        6'h28: mref[a] = rd2[7:0];
        6'h29: begin
          mref[a]   = rd2[15:8];
          mref[a+1] = rd2[7:0];
        end
        6'h2B: begin
          mref[a]   = rd2[31:24];
          mref[a+1] = rd2[23:16];
          mref[a+2] = rd2[15:8];
          mref[a+3] = rd2[7:0];
        end
        default: e.wd = res;
      endcase
    end
    return e;
  endfunction

  // Present one op until accepted; the model is applied at the accept edge.
  // With use_c set, the queued expectation is the given constant instead.
  task automatic issue(input logic [31:0] ins, input logic [31:0] res, input logic [31:0] rd2,
                       input bit use_c, input logic [31:0] c_wd, input logic c_err);
    bit acc = 1'b0;
    int n = 0;
    exp_t e;
    @(negedge CLK);
    InValid = 1'b1;
    Ins = ins;
    Result = res;
    Rdata2 = rd2;
    while (!acc && n < 200) begin
      #1;
      acc = InReady;
      @(posedge CLK);
      n++;
      if (acc) begin
        e = model(ins, res, rd2);
        if (use_c) begin
          e.wd = c_wd;
          e.err = c_err;
        end
        sbq.push_back(e);
      end else begin
        @(negedge CLK);
      end
    end
    #1;
    InValid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ins %h never accepted", ins);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs outstanding, expected 0", sbq.size());
    end
  endtask

  always @(negedge CLK) begin
    OutReady = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  // Monitor: every cycle the output is valid it must match the queue head.
  always begin
    @(negedge CLK);
    #2;
    if (!RST && OutValid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: ins %h wdata %h with empty scoreboard", OutIns, Wdata);
      end else begin
        check("out_ins", OutIns, sbq[0].ins);
        check("wdata", Wdata, sbq[0].wd);
        check("addr_err", {31'd0, AddrErr}, {31'd0, sbq[0].err});
        check("in_ready_full", {31'd0, InReady}, {31'd0, OutReady});
        if (OutReady) void'(sbq.pop_front());
      end
    end
  end

  localparam logic [31:0] I_LB  = 32'h8000_0000;
  localparam logic [31:0] I_LH  = 32'h8400_0000;
  localparam logic [31:0] I_LW  = 32'h8C00_0000;
  localparam logic [31:0] I_LBU = 32'h9000_0000;
  localparam logic [31:0] I_LHU = 32'h9400_0000;
  localparam logic [31:0] I_SB  = 32'hA000_0000;
  localparam logic [31:0] I_SW  = 32'hAC00_0000;

  initial begin
    logic [5:0] ops [10];
    RST = 1'b1;
    InValid = 1'b0;
    Ins = 32'd0;
    Result = 32'd0;
    Rdata2 = 32'd0;
    OutReady = 1'b1;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};

    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    #3;
    check("rst_out_valid", {31'd0, OutValid}, 32'd0);
    check("rst_in_ready", {31'd0, InReady}, 32'd1);
    check("rst_wdata", Wdata, 32'd0);
    check("rst_addr_err", {31'd0, AddrErr}, 32'd0);
    check("rst_out_ins", OutIns, 32'd0);

    // Word round trip with latency checks.
    issue(I_SW, 32'h100, 32'h1234_5678, 1'b1, 32'h100, 1'b0);
    @(negedge CLK);
    #3 check("sw_latency", {31'd0, OutValid}, 32'd1);
    issue(I_LW, 32'h100, 32'd0, 1'b1, 32'h1234_5678, 1'b0);
    @(negedge CLK);
    #3 check("lw_latency_c1", {31'd0, OutValid}, 32'd0);
    @(negedge CLK);
    #3 check("lw_latency_c2", {31'd0, OutValid}, 32'd1);

    // Byte, halfword and alignment cases.
    issue(I_SB,  32'h101, 32'h0000_00AB, 1'b1, 32'h101, 1'b0);
    issue(I_LBU, 32'h101, 32'd0, 1'b1, 32'h0000_00AB, 1'b0);
    issue(I_LB,  32'h101, 32'd0, 1'b1, 32'hFFFF_FFAB, 1'b0);
    issue(I_LW,  32'h100, 32'd0, 1'b1, 32'h12AB_5678, 1'b0);
    issue(I_LH,  32'h102, 32'd0, 1'b1, 32'h0000_5678, 1'b0);
    issue(I_LHU, 32'h100, 32'd0, 1'b1, 32'h0000_12AB, 1'b0);
    issue(I_LH,  32'h103, 32'd0, 1'b1, 32'h0, 1'b1);
    issue(I_SW,  32'h102, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    issue(I_LW,  32'h100, 32'd0, 1'b1, 32'h12AB_5678, 1'b0);
    wait_drain();

    // Back-pressure: hold an ADD for 3 cycles, a SUB waiting behind it.
    @(posedge CLK);
    #1 force_ready = 1'b0;
    issue(32'h0000_0020, 32'h8, 32'd0, 1'b1, 32'h8, 1'b0);
    fork
      issue(32'h0000_0022, 32'h44, 32'd0, 1'b1, 32'h44, 1'b0);
    join_none
    repeat (3) begin
      @(negedge CLK);
      #3;
      check("bp_out_valid", {31'd0, OutValid}, 32'd1);
      check("bp_wdata", Wdata, 32'h8);
      check("bp_in_ready", {31'd0, InReady}, 32'd0);
    end
    @(posedge CLK);
    #1 force_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #3 check("b2b_out_ins", OutIns, 32'h0000_0022);
    wait_drain();

    // Reset during the LOAD cycle: op dropped, RAM untouched.
    issue(I_LW, 32'h100, 32'd0, 1'b1, 32'h12AB_5678, 1'b0);
    RST = 1'b1;
    sbq.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      #3 check("rst_load_out_valid", {31'd0, OutValid}, 32'd0);
    end

    // A store presented together with reset must not be written.
    @(negedge CLK);
    RST = 1'b1;
    InValid = 1'b1;
    Ins = I_SW;
    Result = 32'h100;
    Rdata2 = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    InValid = 1'b0;
    issue(I_LW, 32'h100, 32'd0, 1'b1, 32'h12AB_5678, 1'b0);
    wait_drain();

    // Randomized phase: prefill a 64-byte window, then mixed ops with
    // random upper address bits (wraparound) and random WB stalls.
    for (int w = 0; w < 16; w++) begin
      issue(I_SW, 32'h300 + 32'(4 * w), $urandom, 1'b0, 32'd0, 1'b0);
    end
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ins;
      logic [31:0] res;
      ins = {ops[$urandom_range(0, 9)], 26'($urandom)};
      res = ($urandom & 32'hFFFF_F000) | 32'h300 | 32'($urandom_range(0, 63));
      issue(ins, res, $urandom, 1'b0, 32'd0, 1'b0);
    end
    @(posedge CLK);
    #1;
    rand_ready = 1'b0;
    force_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
